// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: streams len bytes from a TX buffer, captures into an RX buffer.
// Build option SPI_MASTER_LOOPBACK_EN samples the internal MOSI flop instead of the MISO pin.
module spi_frame_master #(
  parameter int DIV = 4,
  parameter int GAP = 2,
  parameter int NB  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] len,
  output logic       busy,
  output logic       done,
  input  logic       tx_we,
  input  logic [4:0] tx_addr,
  input  logic [7:0] tx_data,
  input  logic [4:0] rx_addr,
  output logic [7:0] rx_data,
  output logic       SCK,
  output logic       SSEL,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
  localparam logic [4:0] NB_MAX   = 5'(NB);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW, ST_HOLD} state_t;

  state_t     r_state;
  logic       r_sck;
  logic       r_ssel;
  logic       r_mosi;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_div;
  logic [2:0] r_bit_cnt;
  logic [4:0] r_byte_cnt;
  logic [4:0] r_len;
  logic [7:0] r_tx_shift;
  logic [7:0] r_rx_shift;
  logic       r_rx_we;
  logic [4:0] r_rx_waddr;
  logic [7:0] r_rx_data;
  logic [7:0] r_tx_mem [NB];
  logic [7:0] r_rx_mem [NB];

  logic       w_tx_wr;
  logic       w_accept;
  logic       w_gap_phase;
  logic       w_div_last;
  logic       w_last_bit;
  logic       w_enter_high;
  logic       w_sample;
  logic [7:0] w_tx0;
  logic [7:0] w_tx_next;
  logic [4:0] w_next_addr;

  assign w_tx_wr  = tx_we && !r_busy && (tx_addr < NB_MAX);
  // A write to byte 0 in the accepting cycle must reach the wire immediately.
  assign w_tx0    = (w_tx_wr && (tx_addr == 5'd0)) ? tx_data : r_tx_mem[0];
  assign w_accept = start && (r_state == ST_IDLE) && (len != 5'd0) && (len <= NB_MAX);

  assign w_next_addr  = r_byte_cnt + 5'd1;
  assign w_tx_next    = (w_next_addr < r_len) ? r_tx_mem[w_next_addr] : 8'h00;
  assign w_gap_phase  = (r_state == ST_SETUP) || (r_state == ST_HOLD);
  assign w_div_last   = (r_div == (w_gap_phase ? GAP_LAST : DIV_LAST));
  assign w_last_bit   = (r_byte_cnt == r_len);
  assign w_enter_high = w_div_last &&
                        ((r_state == ST_SETUP) || ((r_state == ST_LOW) && !w_last_bit));

`ifdef SPI_MASTER_LOOPBACK_EN
  logic w_unused_miso;
  assign w_unused_miso = MISO;
  assign w_sample      = r_mosi;
`else
  assign w_sample      = MISO;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sck      <= 1'b0;
      r_ssel     <= 1'b1;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div      <= 8'd0;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= 5'd0;
      r_len      <= 5'd0;
      r_tx_shift <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_div <= 8'd0;
          if (w_accept) begin
            r_state    <= ST_SETUP;
            r_ssel     <= 1'b0;
            r_busy     <= 1'b1;
            r_len      <= len;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 5'd0;
            r_tx_shift <= w_tx0;
            r_mosi     <= w_tx0[7];
          end
        end
        ST_SETUP: begin
          r_div <= w_div_last ? 8'd0 : r_div + 8'd1;
          if (w_div_last) begin
            r_state <= ST_HIGH;
            r_sck   <= 1'b1;
          end
        end
        ST_HIGH: begin
          r_div <= w_div_last ? 8'd0 : r_div + 8'd1;
          if (w_div_last) begin
            r_state <= ST_LOW;
            r_sck   <= 1'b0;
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt  <= 3'd0;
              r_byte_cnt <= w_next_addr;
              r_tx_shift <= w_tx_next;
              r_mosi     <= w_tx_next[7];
            end else begin
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              r_mosi     <= r_tx_shift[6];
            end
          end
        end
        ST_LOW: begin
          r_div <= w_div_last ? 8'd0 : r_div + 8'd1;
          if (w_div_last) begin
            if (w_last_bit) begin
              r_state <= ST_HOLD;
            end else begin
              r_state <= ST_HIGH;
              r_sck   <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          r_div <= w_div_last ? 8'd0 : r_div + 8'd1;
          if (w_div_last) begin
            r_state    <= ST_IDLE;
            r_ssel     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_mosi     <= 1'b0;
            r_byte_cnt <= 5'd0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // MISO is captured on the edge that raises SCK; a full byte is committed one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_shift <= 8'h00;
      r_rx_we    <= 1'b0;
      r_rx_waddr <= 5'd0;
    end else begin
      r_rx_we <= 1'b0;
      if (w_enter_high) begin
        r_rx_shift <= {r_rx_shift[6:0], w_sample};
        if (r_bit_cnt == 3'd7) begin
          r_rx_we    <= 1'b1;
          r_rx_waddr <= r_byte_cnt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_wr) begin
      r_tx_mem[tx_addr] <= tx_data;
    end
  end

  // Not gated by rst, so a byte completing on the reset edge is still kept.
  always_ff @(posedge clk) begin
    if (r_rx_we) begin
      r_rx_mem[r_rx_waddr] <= r_rx_shift;
    end
    r_rx_data <= (rx_addr < NB_MAX) ? r_rx_mem[rx_addr] : 8'h00;
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign SCK     = r_sck;
  assign SSEL    = r_ssel;
  assign MOSI    = r_mosi;

endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master: vector table, random frames and corner sequences
// checked against a byte-level model of the frame and a behavioural mode-0 slave.
module tb_spi_frame_master;
  localparam int DIV = 4;
  localparam int GAP = 2;
  localparam int NB  = 20;

  logic       clk = 1'b0;
  logic       rst, start, tx_we;
  logic [4:0] len, tx_addr, rx_addr;
  logic [7:0] tx_data, rx_data;
  logic       busy, done, SCK, SSEL, MOSI;
  logic       MISO = 1'b0;

  always #5 clk = ~clk;

  spi_frame_master #(.DIV(DIV), .GAP(GAP), .NB(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .tx_we(tx_we), .tx_addr(tx_addr), .tx_data(tx_data),
    .rx_addr(rx_addr), .rx_data(rx_data),
    .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tx_model [NB];
  logic [7:0] rx_model [NB];
  logic [7:0] slave_bytes [32];
  bit         slave_tied = 1'b0;

  // Monitor-owned counters; the stimulus only snapshots and differences them.
  int   mon_busy = 0, mon_done = 0, mon_ssel_low = 0, mon_rise = 0, mon_width = 0;
  logic mosi_q [$];
  logic prev_sck = 1'b0, prev_ssel = 1'b1;
  int   run_len = 0, sbit = 0;
  bit   pulse_seen = 1'b0;
  logic [7:0] sbyte;

  always @(negedge clk) begin
    if (busy) mon_busy++;
    if (done) mon_done++;
    if (!SSEL) mon_ssel_low++;
    if (SCK != prev_sck) begin
      if (prev_sck && run_len != DIV) mon_width++;
      if (!prev_sck && pulse_seen && run_len != DIV) mon_width++;
      run_len = 1;
    end else begin
      run_len++;
    end
    if (SCK && !prev_sck) begin
      mon_rise++;
      mosi_q.push_back(MOSI);
      pulse_seen = 1'b1;
    end
    if (SSEL) pulse_seen = 1'b0;
    if ((prev_ssel && !SSEL) || (prev_sck && !SCK && !SSEL)) begin
      sbit = (prev_ssel && !SSEL) ? 0 : sbit + 1;
      if (slave_tied) MISO = 1'b1;
      else if (sbit < 256) begin
        sbyte = slave_bytes[sbit / 8];
        MISO  = sbyte[7 - (sbit % 8)];
      end else MISO = 1'b0;
    end
    prev_sck  = SCK;
    prev_ssel = SSEL;
  end

  int b_busy, b_done, b_ssel, b_rise, b_width, b_q;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic snap();
    b_busy = mon_busy; b_done = mon_done; b_ssel = mon_ssel_low;
    b_rise = mon_rise; b_width = mon_width; b_q = mosi_q.size();
  endtask

  task automatic write_tx(input int a, input logic [7:0] d);
    @(negedge clk);
    tx_we = 1'b1; tx_addr = 5'(a); tx_data = d;
    if (!busy) tx_model[a] = d;
    @(negedge clk);
    tx_we = 1'b0;
  endtask

  task automatic read_rx(input int a, output logic [7:0] d);
    @(negedge clk);
    rx_addr = 5'(a);
    @(negedge clk);
    d = rx_data;
  endtask

  task automatic pulse_start(input int n, input bit wr, input logic [7:0] d);
    @(negedge clk);
    snap();
    start = 1'b1; len = 5'(n);
    if (wr) begin
      tx_we = 1'b1; tx_addr = 5'd0; tx_data = d;
      if (!busy) tx_model[0] = d;
    end
    @(negedge clk);
    start = 1'b0; tx_we = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    check("frame_end_timeout", int'(ok), 1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] exp_rx(input int k);
`ifdef SPI_MASTER_LOOPBACK_EN
    return tx_model[k];
`else
    return slave_tied ? 8'hFF : slave_bytes[k];
`endif
  endfunction

  task automatic frame_checks(input int n);
    logic [7:0] b, r;
    int t = 2 * GAP + 16 * DIV * n;
    check("busy_cycles", mon_busy - b_busy, t);
    check("ssel_low_cycles", mon_ssel_low - b_ssel, t);
    check("done_pulses", mon_done - b_done, 1);
    check("sck_rises", mon_rise - b_rise, 8 * n);
    check("sck_width_errors", mon_width - b_width, 0);
    for (int k = 0; k < n; k++) begin
      b = 8'h00;
      for (int j = 0; j < 8; j++)
        b = {b[6:0], (b_q + 8 * k + j < mosi_q.size()) ? mosi_q[b_q + 8 * k + j] : 1'b0};
      check($sformatf("mosi_byte%0d", k), int'(b), int'(tx_model[k]));
      rx_model[k] = exp_rx(k);
    end
    for (int k = 0; k < n; k++) begin
      read_rx(k, r);
      check($sformatf("rx_byte%0d", k), int'(r), int'(rx_model[k]));
    end
  endtask

  typedef struct {
    int         n;
    logic [7:0] tx_base;
    logic [7:0] tx_step;
    logic [7:0] sl_base;
    bit         tied;
    bit         exp_acc;
  } vec_t;

  vec_t vecs [7];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    bit         ok;
    int         n;

    vecs[0] = '{1,  8'hA5, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[1] = '{20, 8'h00, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{0,  8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{21, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{31, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{2,  8'hF0, 8'h11, 8'h3C, 1'b0, 1'b1};
    vecs[6] = '{5,  8'h0F, 8'h33, 8'hC0, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; len = 5'd0; tx_we = 1'b0;
    tx_addr = 5'd0; tx_data = 8'h00; rx_addr = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_ssel", int'(SSEL), 1);
    check("reset_sck", int'(SCK), 0);
    check("reset_mosi", int'(MOSI), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      n = vecs[v].n;
      if (vecs[v].exp_acc)
        for (int k = 0; k < n; k++) write_tx(k, 8'(vecs[v].tx_base + k * vecs[v].tx_step));
      for (int k = 0; k < 32; k++) slave_bytes[k] = 8'(vecs[v].sl_base + k);
      slave_tied = vecs[v].tied;
      pulse_start(n, 1'b0, 8'h00);
      check($sformatf("accept_len%0d", n), int'(busy), int'(vecs[v].exp_acc));
      if (vecs[v].exp_acc) begin
        wait_idle();
        frame_checks(n);
      end else begin
        repeat (6) @(negedge clk);
        check("illegal_ssel_low", mon_ssel_low - b_ssel, 0);
        check("illegal_done", mon_done - b_done, 0);
      end
    end

    slave_tied = 1'b0;
    for (int it = 0; it < 5; it++) begin
      n = int'($urandom_range(1, NB));
      for (int k = 0; k < n; k++) write_tx(k, 8'($urandom));
      for (int k = 0; k < 32; k++) slave_bytes[k] = 8'($urandom);
      pulse_start(n, 1'b0, 8'h00);
      wait_idle();
      frame_checks(n);
    end

    // start while busy is ignored; tx write while busy does not alter the frame
    write_tx(0, 8'h11);
    write_tx(1, 8'h22);
    write_tx(2, 8'h33);
    pulse_start(3, 1'b0, 8'h00);
    repeat (20) @(negedge clk);
    start = 1'b1; len = 5'd2;
    @(negedge clk);
    start = 1'b0;
    write_tx(0, 8'h3C);
    wait_idle();
    frame_checks(3);
    snap();
    repeat (6) @(negedge clk);
    check("no_restart_after_busy_start", mon_ssel_low - b_ssel, 0);

    // start and tx_we together: byte 0 takes the new value
    pulse_start(1, 1'b1, 8'h3C);
    wait_idle();
    frame_checks(1);

    // reset during byte 2 of a 5-byte frame
    for (int k = 0; k < 5; k++) write_tx(k, 8'(8'h90 + k));
    for (int k = 0; k < 32; k++) slave_bytes[k] = 8'(8'h50 + 3 * k);
    pulse_start(5, 1'b0, 8'h00);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (mon_rise - b_rise >= 17) begin ok = 1'b1; break; end
    end
    check("rst_mid_wait", int'(ok), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ssel", int'(SSEL), 1);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_sck", int'(SCK), 0);
    repeat (6) @(negedge clk);
    check("rst_mid_no_done", mon_done - b_done, 0);
    rx_model[0] = exp_rx(0);
    rx_model[1] = exp_rx(1);
    for (int k = 0; k < 5; k++) begin
      read_rx(k, r);
      check($sformatf("rst_mid_rx%0d", k), int'(r), int'(rx_model[k]));
    end

    // rst and start in the same cycle: reset wins
    @(negedge clk);
    snap();
    rst = 1'b1; start = 1'b1; len = 5'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", int'(busy), 0);
    repeat (6) @(negedge clk);
    check("rst_start_ssel_low", mon_ssel_low - b_ssel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
